instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; clk is the clock and resetN is the reset.
REQ-002 The ports SHALL be, in this order:
- clk  in  1  clock
- resetN  in  1  async active-low reset
- romAddressOut  out  4  program ROM address
- romDataIn  in  4  ROM data; registered, valid one cycle after its address is sampled
- instrOut  out  4  opcode presented to decode
- instrAddrOut  out  4  ROM address instrOut came from
- instrValid  out  1  instrOut valid
- instrReady  in  1  decode accepts instrOut
- skipIn  in  1  conditional skip taken; sampled only at handshake
- haltIn  in  1  stop request; sampled only at handshake
- haltedOut  out  1  fetch stopped

Function
REQ-003 The block SHALL hold a 4-bit pc, the next ROM address to fetch, and drive romAddressOut = pc at all times.
REQ-004 The FSM SHALL have exactly four states: ISSUE, CAPTURE, VALID, HALTED.
REQ-005 ISSUE SHALL go unconditionally to CAPTURE on the next edge; the ROM samples romAddressOut at that edge.
REQ-006 CAPTURE SHALL, on the next edge: load instrOut <= romDataIn and instrAddrOut <= pc, advance pc by one (REQ-011 governs overflow), and go to VALID.
REQ-007 instrValid SHALL be 1 only in VALID; instrOut and instrAddrOut SHALL stay stable while instrValid=1 and instrReady=0.
REQ-008 A handshake is instrValid=1 and instrReady=1 at an edge. At a handshake the FSM SHALL:
- go to HALTED if haltIn=1 (haltIn wins over skipIn);
- otherwise, if skipIn=1, advance pc by one more and go to ISSUE;
- otherwise go to ISSUE.
REQ-009 HALTED SHALL hold instrValid=0 and haltedOut=1, keep pc frozen, and be left only by reset.
REQ-010 Latency: first instrValid=1 SHALL occur after the second edge following reset release; steady state with instrReady tied 1 SHALL be one instruction per 3 cycles.
REQ-011 pc advance SHALL be computed 5 bits wide; overflow past 15 is governed by REQ-016/REQ-017.
REQ-012 skipIn and haltIn SHALL be ignored in every cycle that is not a handshake.

Reset
REQ-013 While resetN=0, the block SHALL hold: state ISSUE, pc=0, romAddressOut=0, instrOut=4'b0111 (CLR/NOP), instrAddrOut=0, instrValid=0, haltedOut=0.
REQ-014 Reset assertion mid-operation, including in HALTED or VALID, SHALL force the REQ-013 values immediately, without waiting for a clock edge; any pending instruction is discarded.
REQ-015 After resetN deasserts, the first active edge SHALL act as an ISSUE edge for address 0.

Configuration
REQ-016 With macro FETCH_WRAP_EN defined, pc SHALL wrap modulo 16 (15+1 -> 0; a skip from 15 -> 1), and the block never halts except via haltIn.
REQ-017 Without FETCH_WRAP_EN, any pc advance producing a value above 15 SHALL send the FSM to HALTED instead of ISSUE. This includes the CAPTURE advance and the skip advance. The instruction already captured (for example from address 15) SHALL still be presented and handshaken first, and pc SHALL hold 15.

Verification
REQ-018 The bench SHALL use a registered ROM model with program 0:0000, 1:0001, 2:1010, 3:0010, 4:0100, 5:0101, 6:1000, 7:0010, others 0111, and SHALL cover these scenarios:
- Reset, instrReady=1, skipIn=haltIn=0: instrOut sequence 0000, 0001, 1010, 0010, ... with instrAddrOut 0,1,2,3; first instrValid after the 2nd edge; instrValid pulses every 3 cycles.
- instrReady=0 for 5 cycles while instr@2 is valid: instrOut=1010 and instrAddrOut=2 held; no further ROM address change until the handshake.
- skipIn=1 at the handshake of instr@6 (1000): the next instruction is from address 8 (0111) with instrAddrOut=8; skipIn=1 outside a handshake has no effect.
- haltIn=1 at the handshake of instr@3: haltedOut=1, instrValid=0 persist for 20 cycles; pulsing resetN low restarts from address 0.
- resetN asserted in CAPTURE: outputs return to the REQ-013 values without a clock edge.
- Run through address 15: with FETCH_WRAP_EN the next instrAddrOut is 0; without it, instr@15 is accepted, then HALTED with pc=15. A skip at address 14 without the macro also halts.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch -- three-cycle fetch sequencer for a 16-word program ROM.
// Issues the pc to a registered ROM and captures the returned opcode. It then
// presents the opcode to decode with a valid/ready handshake. Decode can request
// a conditional skip or a halt at the handshake.
//
// Build option: FETCH_WRAP_EN
//   defined   -> pc wraps modulo 16, and fetch halts only on haltIn.
//   undefined -> any pc advance past 15 ends in HALTED. The last captured
//                opcode is still handed to decode first, and pc stays at 15.
module instruction_fetch (
    input  logic       clk,
    input  logic       resetN,
    output logic [3:0] romAddressOut,
    input  logic [3:0] romDataIn,
    output logic [3:0] instrOut,
    output logic [3:0] instrAddrOut,
    output logic       instrValid,
    input  logic       instrReady,
    input  logic       skipIn,
    input  logic       haltIn,
    output logic       haltedOut
);

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;

    // Opcode shown while nothing has been fetched yet (CLR/NOP).
    localparam logic [DATA_W-1:0] NOP_OP = 4'b0111;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        CAPTURE = 2'd1,
        VALID   = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t state;

    // Next ROM address to fetch.
    logic [ADDR_W-1:0] pc;

    // pc + 1 with a carry bit, so overflow past 15 is visible.
    logic [ADDR_W:0]   pc_inc;

    // Decode is taking instrOut at the coming edge.
    logic              handshake;

`ifndef FETCH_WRAP_EN
    // Set when the CAPTURE advance overflowed. The opcode just captured must
    // still be handed over. After that, fetch stops instead of issuing again.
    logic              ovf_pend;
`endif

    // Wide pc increment. The carry bit reports overflow past the top address.
    function automatic logic [ADDR_W:0] pc_advance(input logic [ADDR_W-1:0] a);
        return {1'b0, a} + {{ADDR_W{1'b0}}, 1'b1};
    endfunction

    // True when a wide pc advance has left the 16-word address space.
    function automatic logic pc_overflow(input logic [ADDR_W:0] wide);
        return wide[ADDR_W];
    endfunction

    assign pc_inc        = pc_advance(pc);
    assign handshake     = instrValid & instrReady;
    assign romAddressOut = pc;

`ifdef FETCH_WRAP_EN

    // Fetch FSM, wrapping variant: pc rolls over, and only haltIn stops fetching.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= ISSUE;
            pc           <= '0;
            instrOut     <= NOP_OP;
            instrAddrOut <= '0;
            instrValid   <= 1'b0;
            haltedOut    <= 1'b0;
        end else begin
            case (state)
                // The ROM samples romAddressOut at this edge.
                ISSUE: begin
                    state <= CAPTURE;
                end

                // ROM data for pc is now on romDataIn.
                CAPTURE: begin
                    instrOut     <= romDataIn;
                    instrAddrOut <= pc;
                    pc           <= pc_inc[ADDR_W-1:0];
                    instrValid   <= 1'b1;
                    state        <= VALID;
                end

                // Hold the opcode until decode takes it.
                VALID: begin
                    if (handshake) begin
                        instrValid <= 1'b0;
                        if (haltIn) begin
                            haltedOut <= 1'b1;
                            state     <= HALTED;
                        end else if (skipIn) begin
                            pc    <= pc_inc[ADDR_W-1:0];
                            state <= ISSUE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end

                // Terminal: only reset leaves this state.
                HALTED: begin
                    state <= HALTED;
                end

                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

`else

    // Fetch FSM, halting variant: stop instead of wrapping, and keep pc at 15.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= ISSUE;
            pc           <= '0;
            instrOut     <= NOP_OP;
            instrAddrOut <= '0;
            instrValid   <= 1'b0;
            haltedOut    <= 1'b0;
            ovf_pend     <= 1'b0;
        end else begin
            case (state)
                // The ROM samples romAddressOut at this edge.
                ISSUE: begin
                    state <= CAPTURE;
                end

                // Capture the opcode. If the advance overflows, pc stays at 15
                // and the overflow is noted for the coming handshake.
                CAPTURE: begin
                    instrOut     <= romDataIn;
                    instrAddrOut <= pc;
                    instrValid   <= 1'b1;
                    state        <= VALID;
                    if (pc_overflow(pc_inc)) begin
                        ovf_pend <= 1'b1;
                    end else begin
                        pc <= pc_inc[ADDR_W-1:0];
                    end
                end

                // Hold the opcode until decode takes it. An overflowing skip or
                // a pending overflow both end in HALTED.
                VALID: begin
                    if (handshake) begin
                        instrValid <= 1'b0;
                        if (haltIn) begin
                            haltedOut <= 1'b1;
                            state     <= HALTED;
                        end else if (skipIn) begin
                            if (ovf_pend || pc_overflow(pc_inc)) begin
                                haltedOut <= 1'b1;
                                state     <= HALTED;
                            end else begin
                                pc    <= pc_inc[ADDR_W-1:0];
                                state <= ISSUE;
                            end
                        end else if (ovf_pend) begin
                            haltedOut <= 1'b1;
                            state     <= HALTED;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end

                // Terminal: only reset leaves this state.
                HALTED: begin
                    state <= HALTED;
                end

                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

`endif

endmodule
